dense_layer_serial: RTL and testbench
=====================================

# dense_layer_serial

Parametrised, time-multiplexed fully-connected layer for the fixed-point network datapath. It computes `outputs[j] = act(bias[j] + Σ_i weights[j][i]·inputs[i])` using `NUM_MACS` shared multiply-accumulate lanes, and supports selectable activation, saturating rounding and a saturation flag. It connects into the layer chain through the network's existing `inputs_ready` / `outputs_ready` handshake.

## Interface
Parameters:
- `INTEGER_WIDTH`, default 8: integer bits of the signed fixed-point format, sign bit included.
- `FRACTION_WIDTH`, default 8: fraction bits. W = `INTEGER_WIDTH` + `FRACTION_WIDTH`.
- `NUM_INPUTS`, default 16: fan-in, ≥1.
- `NUM_OUTPUTS`, default 16: number of neurons, ≥1.
- `NUM_MACS`, default 4: parallel MAC lanes, 1..`NUM_OUTPUTS`.
- `ACTIVATION`, default `RELU`: one of `NONE`, `RELU`, `LEAKY_RELU`.

Ports:
- `clock`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-low reset.
- `inputs_ready`  input  1  request to start; `inputs` is valid while it is high.
- `inputs`  input  W×`NUM_INPUTS`  signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] array.
- `weights`  input  W×`NUM_OUTPUTS`×`NUM_INPUTS`  must be held stable while `busy`.
- `biases`  input  W×`NUM_OUTPUTS`  must be held stable while `busy`.
- `busy`  output  1  high from accept until the result is written.
- `outputs_ready`  output  1  level; high while `outputs` is valid.
- `outputs`  output  W×`NUM_OUTPUTS`  registered results.
- `saturated`  output  1  high with `outputs_ready` if any output clipped.

## Operation
- States: IDLE, ACCUMULATE, WRITE, DONE.
- Accept:
  - In IDLE or DONE, `inputs_ready`=1 at an edge captures `inputs` into an internal register.
  - At the same edge, the lanes are loaded with `bias << FRACTION_WIDTH` for group 0, index is set to 0 and the state goes to ACCUMULATE.
  - At that edge `outputs_ready` clears and `busy` sets. `outputs` keeps its old value until overwritten.
- Grouping: neurons are processed in G = ceil(`NUM_OUTPUTS`/`NUM_MACS`) groups. Lane l of group g serves neuron g·`NUM_MACS`+l. In a ragged last group, lanes with no neuron are computed but discarded.
- ACCUMULATE: each edge adds `weights[j][index]·x[index]` (2W-bit signed product) to each lane and increments index. After index `NUM_INPUTS`-1 is consumed, the state goes to WRITE.
- WRITE, one edge:
  - Each lane result is arithmetic-shifted right by `FRACTION_WIDTH` (truncation toward −∞).
  - It is then saturated to [−2^(W−1), 2^(W−1)−1].
  - The activation is applied and the result is stored to `outputs[j]`.
  - The saturation flag is ORed.
  - If g < G−1, the next group's biases are loaded and the state goes to ACCUMULATE. Otherwise the state goes to DONE.
- Activation, applied after saturation:
  - `NONE`: identity.
  - `RELU`: negative values become 0.
  - `LEAKY_RELU`: negative values become x>>>3.
- Accumulator width: 2W + clog2(`NUM_INPUTS`+1). It must never overflow internally.
- DONE: `outputs_ready`=1, `busy`=0. `outputs` and `saturated` are held until the next accept.
- `inputs_ready` while `busy` is ignored. No queueing.
- Reset (`reset`=0 at an edge), in any state including mid-accumulation:
  - The state returns to IDLE.
  - `outputs` becomes all 0; `outputs_ready`, `busy` and `saturated` become 0.
  - The captured inputs, lanes and index become 0.
  - Reset has priority over `inputs_ready`.

## Timing
- Accept at edge k. `outputs_ready` and `saturated` rise after edge k + G·(`NUM_INPUTS`+1).
- Example: `NUM_INPUTS`=4, `NUM_OUTPUTS`=3, `NUM_MACS`=2 gives G=2, so the latency is 10 cycles.
- `busy` is high after edges k .. k+G·(`NUM_INPUTS`+1)−1.
- Group g results appear on `outputs` after edge k + (g+1)·(`NUM_INPUTS`+1). `outputs` is only guaranteed as a whole set once `outputs_ready` is high.
- Back-to-back: if `inputs_ready` is high in DONE, the next accept occurs at the first DONE edge. `outputs_ready` is then high for exactly one cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
All scenarios use Q8.8, so 1.0 = 0x0100.
- `NONE` with N_IN=4, N_OUT=3, MACS=2: inputs all 1.0, weights 0.5, biases 0.25 → every output 0x0240 (2.25), `saturated`=0, `outputs_ready` rises 10 cycles after accept, `busy` high exactly 10 cycles.
- Activation variants: weights −1.0, inputs 1.0, biases 0 → `NONE` gives 0xFC00, `RELU` gives 0x0000, `LEAKY_RELU` gives 0xFF80 (−0.5).
- Saturation: inputs 100.0, weights ±100.0 (`NONE`) → 0x7FFF for positive weights and 0x8000 for negative weights, `saturated`=1. A following normal run clears `saturated` to 0.
- Truncation:
  - Input 0x0001 × weight 0x0001, bias 0 → 0x0000.
  - Input 0xFFFF × weight 0x0001 (`NONE`) → 0xFFFF.
- Reset mid-run:
  - Drive `reset`=0 for one edge 5 cycles after accept → next cycle `outputs` all 0, `outputs_ready`=0, `busy`=0.
  - A fresh accept afterwards gives correct results with full latency.
- Handshake robustness:
  - Toggle `inputs_ready` and change `inputs` while `busy` → results reflect only the first capture.
  - Hold `inputs_ready` high through DONE → restart at the first DONE cycle, `outputs_ready` high for one cycle.
  - Test with MACS=1 and MACS=`NUM_OUTPUTS`; latency must match G·(`NUM_INPUTS`+1).

Source files
------------

// File: rtl/dense_layer_serial.sv
// Time-multiplexed fully-connected layer: NUM_MACS shared lanes sweep the neurons in groups,
// then shift, saturate and activate each lane result into the registered output array.
module dense_layer_serial #(
    parameter int unsigned INTEGER_WIDTH  = 8,
    parameter int unsigned FRACTION_WIDTH = 8,
    parameter int unsigned NUM_INPUTS     = 16,
    parameter int unsigned NUM_OUTPUTS    = 16,
    parameter int unsigned NUM_MACS       = 4,
    parameter string       ACTIVATION     = "RELU"
) (
    input  logic                                                          clock,
    input  logic                                                          reset,
    input  logic                                                          inputs_ready,
    input  logic [(INTEGER_WIDTH+FRACTION_WIDTH)*NUM_INPUTS-1:0]             inputs,
    input  logic [(INTEGER_WIDTH+FRACTION_WIDTH)*NUM_OUTPUTS*NUM_INPUTS-1:0] weights,
    input  logic [(INTEGER_WIDTH+FRACTION_WIDTH)*NUM_OUTPUTS-1:0]            biases,
    output logic                                                          busy,
    output logic                                                          outputs_ready,
    output logic [(INTEGER_WIDTH+FRACTION_WIDTH)*NUM_OUTPUTS-1:0]            outputs,
    output logic                                                          saturated
);

    localparam int unsigned W       = INTEGER_WIDTH + FRACTION_WIDTH;
    localparam int unsigned PW      = 2 * W;
    localparam int unsigned AW      = PW + $clog2(NUM_INPUTS + 1);
    localparam int unsigned G       = (NUM_OUTPUTS + NUM_MACS - 1) / NUM_MACS;
    localparam int unsigned IW      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int unsigned GW      = (G > 1) ? $clog2(G) : 1;
    localparam int unsigned ACT_SEL = (ACTIVATION == "NONE") ? 0 :
                                      ((ACTIVATION == "LEAKY_RELU") ? 2 : 1);

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [W-1:0]  MAX_W   = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]  MIN_W   = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_WRITE, S_DONE} state_t;

    state_t                 state_q;
    logic [IW-1:0]          idx_q;
    logic [GW-1:0]          grp_q;
    logic signed [W-1:0]    x_q   [NUM_INPUTS];
    logic signed [AW-1:0]   acc_q [NUM_MACS];
    logic [W*NUM_OUTPUTS-1:0] out_q;
    logic                   busy_q, ready_q, sat_q, sat_acc_q;

    logic [GW-1:0]          load_grp_d;
    logic signed [W-1:0]    bias_d  [NUM_MACS];
    logic signed [W-1:0]    wt_d    [NUM_MACS];
    logic signed [W-1:0]    xv_d;
    logic signed [PW-1:0]   prod_d  [NUM_MACS];
    logic                   valid_d [NUM_MACS];
    logic signed [AW-1:0]   sh_d    [NUM_MACS];
    logic signed [W-1:0]    res_d   [NUM_MACS];
    logic signed [W-1:0]    act_d   [NUM_MACS];
    logic                   clip_any_d;

    assign busy          = busy_q;
    assign outputs_ready = ready_q;
    assign outputs       = out_q;
    assign saturated     = sat_q;

    // Bias preload for group 0 on accept, or the following group at the end of a WRITE
    always_comb begin : bias_select
        load_grp_d = (state_q == S_WRITE) ? grp_q + GW'(1) : '0;
        for (int l = 0; l < NUM_MACS; l++) begin
            bias_d[l] = '0;
            if (32'(load_grp_d) * NUM_MACS + 32'(l) < NUM_OUTPUTS)
                bias_d[l] = biases[(32'(load_grp_d) * NUM_MACS + 32'(l)) * W +: W];
        end
    end

    always_comb begin : mac_operands
        xv_d = x_q[idx_q];
        for (int l = 0; l < NUM_MACS; l++) begin
            valid_d[l] = (32'(grp_q) * NUM_MACS + 32'(l) < NUM_OUTPUTS);
            wt_d[l]    = '0;
            if (valid_d[l])
                wt_d[l] = weights[((32'(grp_q) * NUM_MACS + 32'(l)) * NUM_INPUTS + 32'(idx_q)) * W +: W];
            prod_d[l]  = PW'(wt_d[l]) * PW'(xv_d);
        end
    end

    // Floor shift, clip to W bits, then activation; clipping only counts on real neurons
    always_comb begin : lane_write
        clip_any_d = 1'b0;
        for (int l = 0; l < NUM_MACS; l++) begin
            sh_d[l]  = acc_q[l] >>> FRACTION_WIDTH;
            res_d[l] = sh_d[l][W-1:0];
            if (sh_d[l] > SAT_MAX) begin
                res_d[l] = MAX_W;
                if (valid_d[l]) clip_any_d = 1'b1;
            end else if (sh_d[l] < SAT_MIN) begin
                res_d[l] = MIN_W;
                if (valid_d[l]) clip_any_d = 1'b1;
            end
            act_d[l] = res_d[l];
            if (ACT_SEL == 1 && res_d[l][W-1]) act_d[l] = '0;
            else if (ACT_SEL == 2 && res_d[l][W-1]) act_d[l] = res_d[l] >>> 3;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            grp_q     <= '0;
            out_q     <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            sat_q     <= 1'b0;
            sat_acc_q <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) x_q[i] <= '0;
            for (int l = 0; l < NUM_MACS; l++) acc_q[l] <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (inputs_ready) begin
                        for (int i = 0; i < NUM_INPUTS; i++) x_q[i] <= inputs[i * W +: W];
                        for (int l = 0; l < NUM_MACS; l++) acc_q[l] <= AW'(bias_d[l]) <<< FRACTION_WIDTH;
                        idx_q     <= '0;
                        grp_q     <= '0;
                        sat_acc_q <= 1'b0;
                        sat_q     <= 1'b0;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    for (int l = 0; l < NUM_MACS; l++) acc_q[l] <= acc_q[l] + AW'(prod_d[l]);
                    idx_q <= idx_q + IW'(1);
                    if (idx_q == IW'(NUM_INPUTS - 1)) state_q <= S_WRITE;
                end
                S_WRITE: begin
                    for (int l = 0; l < NUM_MACS; l++)
                        if (valid_d[l])
                            out_q[(32'(grp_q) * NUM_MACS + 32'(l)) * W +: W] <= act_d[l];
                    if (grp_q == GW'(G - 1)) begin
                        sat_q   <= sat_acc_q | clip_any_d;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        for (int l = 0; l < NUM_MACS; l++) acc_q[l] <= AW'(bias_d[l]) <<< FRACTION_WIDTH;
                        sat_acc_q <= sat_acc_q | clip_any_d;
                        grp_q     <= load_grp_d;
                        idx_q     <= '0;
                        state_q   <= S_ACCUM;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer_serial.sv
// Bench for dense_layer_serial: three Q8.8 instances (NONE/2 lanes, RELU/1 lane, LEAKY_RELU/3 lanes)
// share one stimulus; directed vectors plus reset, handshake and back-to-back sequences.
module tb_dense_layer_serial;

    localparam int LAT_N = 10;
    localparam int LAT_R = 15;
    localparam int LAT_L = 5;

    typedef struct {
        logic [15:0] x;
        logic [15:0] w;
        logic [15:0] b;
        bit          neg1;
        logic [47:0] exp_n;
        logic [47:0] exp_r;
        logic [47:0] exp_l;
        bit          exp_sat;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ir;
    logic [63:0]  x_bus;
    logic [191:0] w_bus;
    logic [47:0]  b_bus;
    logic         busy_n, busy_r, busy_l;
    logic         rdy_n, rdy_r, rdy_l;
    logic         sat_n, sat_r, sat_l;
    logic [47:0]  out_n, out_r, out_l;

    int checks = 0;
    int errors = 0;
    vec_t vecs [7];

    always #5 clk = ~clk;

    dense_layer_serial #(.INTEGER_WIDTH(8), .FRACTION_WIDTH(8), .NUM_INPUTS(4), .NUM_OUTPUTS(3),
                         .NUM_MACS(2), .ACTIVATION("NONE")) dut_n (
        .clock(clk), .reset(rst_n), .inputs_ready(ir), .inputs(x_bus), .weights(w_bus[191:0]),
        .biases(b_bus), .busy(busy_n), .outputs_ready(rdy_n), .outputs(out_n), .saturated(sat_n));

    dense_layer_serial #(.INTEGER_WIDTH(8), .FRACTION_WIDTH(8), .NUM_INPUTS(4), .NUM_OUTPUTS(3),
                         .NUM_MACS(1), .ACTIVATION("RELU")) dut_r (
        .clock(clk), .reset(rst_n), .inputs_ready(ir), .inputs(x_bus), .weights(w_bus[191:0]),
        .biases(b_bus), .busy(busy_r), .outputs_ready(rdy_r), .outputs(out_r), .saturated(sat_r));

    dense_layer_serial #(.INTEGER_WIDTH(8), .FRACTION_WIDTH(8), .NUM_INPUTS(4), .NUM_OUTPUTS(3),
                         .NUM_MACS(3), .ACTIVATION("LEAKY_RELU")) dut_l (
        .clock(clk), .reset(rst_n), .inputs_ready(ir), .inputs(x_bus), .weights(w_bus[191:0]),
        .biases(b_bus), .busy(busy_l), .outputs_ready(rdy_l), .outputs(out_l), .saturated(sat_l));

    function automatic vec_t mk(input logic [15:0] x, input logic [15:0] w, input logic [15:0] b,
                                input bit neg1, input logic [47:0] en, input logic [47:0] er,
                                input logic [47:0] el, input bit es);
        vec_t v;
        v.x = x; v.w = w; v.b = b; v.neg1 = neg1;
        v.exp_n = en; v.exp_r = er; v.exp_l = el; v.exp_sat = es;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Uniform inputs/weights/biases; neg1 negates every weight of neuron 1
    task automatic set_stim(input vec_t v);
        logic [15:0] wn;
        wn = -v.w;
        x_bus = {4{v.x}};
        b_bus = {3{v.b}};
        w_bus = '0;
        for (int j = 0; j < 3; j++)
            for (int i = 0; i < 4; i++)
                w_bus[(j * 4 + i) * 16 +: 16] = (v.neg1 && j == 1) ? wn : v.w;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int ln, lr, ll, bn, br, bl;
        set_stim(v);
        ir = 1'b1;
        step();
        ir = 1'b0;
        ln = 0; lr = 0; ll = 0;
        bn = int'(busy_n); br = int'(busy_r); bl = int'(busy_l);
        for (int c = 1; c < 40; c++) begin
            step();
            if (rdy_n && ln == 0) ln = c;
            if (rdy_r && lr == 0) lr = c;
            if (rdy_l && ll == 0) ll = c;
            bn += int'(busy_n); br += int'(busy_r); bl += int'(busy_l);
        end
        chk({tag, " lat_none"},  64'(ln), 64'(LAT_N));
        chk({tag, " lat_relu"},  64'(lr), 64'(LAT_R));
        chk({tag, " lat_leaky"}, 64'(ll), 64'(LAT_L));
        chk({tag, " busy_none"},  64'(bn), 64'(LAT_N));
        chk({tag, " busy_relu"},  64'(br), 64'(LAT_R));
        chk({tag, " busy_leaky"}, 64'(bl), 64'(LAT_L));
        chk({tag, " out_none"},  64'(out_n), 64'(v.exp_n));
        chk({tag, " out_relu"},  64'(out_r), 64'(v.exp_r));
        chk({tag, " out_leaky"}, 64'(out_l), 64'(v.exp_l));
        chk({tag, " sat_none"},  64'(sat_n), 64'(v.exp_sat));
        chk({tag, " sat_relu"},  64'(sat_r), 64'(v.exp_sat));
        chk({tag, " sat_leaky"}, 64'(sat_l), 64'(v.exp_sat));
    endtask

    initial begin
        logic [20:0] m_n, m_r, m_l, e_n, e_r, e_l;

        vecs[0] = mk(16'h0100, 16'h0080, 16'h0040, 1'b0,
                     {3{16'h0240}}, {3{16'h0240}}, {3{16'h0240}}, 1'b0);
        vecs[1] = mk(16'h0100, 16'hFF00, 16'h0000, 1'b0,
                     {3{16'hFC00}}, {3{16'h0000}}, {3{16'hFF80}}, 1'b0);
        vecs[2] = mk(16'h6400, 16'h6400, 16'h0000, 1'b1,
                     {16'h7FFF, 16'h8000, 16'h7FFF}, {16'h7FFF, 16'h0000, 16'h7FFF},
                     {16'h7FFF, 16'hF000, 16'h7FFF}, 1'b1);
        vecs[3] = mk(16'h0200, 16'h0100, 16'hFF00, 1'b1,
                     {16'h0700, 16'hF700, 16'h0700}, {16'h0700, 16'h0000, 16'h0700},
                     {16'h0700, 16'hFEE0, 16'h0700}, 1'b0);
        vecs[4] = mk(16'h0001, 16'h0001, 16'h0000, 1'b0,
                     48'h0, 48'h0, 48'h0, 1'b0);
        vecs[5] = mk(16'hFFFF, 16'h0001, 16'h0000, 1'b0,
                     {3{16'hFFFF}}, 48'h0, {3{16'hFFFF}}, 1'b0);
        vecs[6] = mk(16'h0180, 16'hFFC0, 16'h0010, 1'b1,
                     {16'hFE90, 16'h0190, 16'hFE90}, {16'h0000, 16'h0190, 16'h0000},
                     {16'hFFD2, 16'h0190, 16'hFFD2}, 1'b0);

        rst_n = 1'b0;
        ir    = 1'b0;
        set_stim(vecs[0]);
        step();
        step();
        chk("reset out_none",  64'(out_n), 64'h0);
        chk("reset out_relu",  64'(out_r), 64'h0);
        chk("reset out_leaky", 64'(out_l), 64'h0);
        chk("reset flags_none",  64'({rdy_n, busy_n, sat_n}), 64'h0);
        chk("reset flags_relu",  64'({rdy_r, busy_r, sat_r}), 64'h0);
        chk("reset flags_leaky", 64'({rdy_l, busy_l, sat_l}), 64'h0);
        rst_n = 1'b1;
        step();

        for (int k = 0; k < 7; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // inputs_ready toggling and inputs changing while busy must not disturb the first capture
        set_stim(vecs[0]);
        ir = 1'b1;
        step();
        for (int c = 1; c <= 4; c++) begin
            ir    = (c % 2 == 1);
            x_bus = {4{16'h0200}};
            step();
        end
        ir = 1'b0;
        repeat (36) step();
        chk("busy_toggle out_none",  64'(out_n), 64'(vecs[0].exp_n));
        chk("busy_toggle out_relu",  64'(out_r), 64'(vecs[0].exp_r));
        chk("busy_toggle out_leaky", 64'(out_l), 64'(vecs[0].exp_l));
        chk("busy_toggle ready", 64'({rdy_n, rdy_r, rdy_l}), 64'h7);

        // inputs_ready held through DONE: restart on the first DONE edge, ready lasts one cycle
        set_stim(vecs[0]);
        ir = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            step();
            m_n[c] = rdy_n;
            m_r[c] = rdy_r;
            m_l[c] = rdy_l;
            e_n[c] = (c == LAT_N);
            e_r[c] = (c == LAT_R);
            e_l[c] = (c % (LAT_L + 1) == LAT_L);
        end
        ir = 1'b0;
        chk("hold ready_none",  64'(m_n), 64'(e_n));
        chk("hold ready_relu",  64'(m_r), 64'(e_r));
        chk("hold ready_leaky", 64'(m_l), 64'(e_l));
        repeat (40) step();
        chk("hold out_none",  64'(out_n), 64'(vecs[0].exp_n));
        chk("hold out_relu",  64'(out_r), 64'(vecs[0].exp_r));
        chk("hold out_leaky", 64'(out_l), 64'(vecs[0].exp_l));

        // Reset one edge, five cycles after an accept, then a clean rerun
        set_stim(vecs[3]);
        ir = 1'b1;
        step();
        ir = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midreset out_none",  64'(out_n), 64'h0);
        chk("midreset out_relu",  64'(out_r), 64'h0);
        chk("midreset out_leaky", 64'(out_l), 64'h0);
        chk("midreset flags_none",  64'({rdy_n, busy_n, sat_n}), 64'h0);
        chk("midreset flags_relu",  64'({rdy_r, busy_r, sat_r}), 64'h0);
        chk("midreset flags_leaky", 64'({rdy_l, busy_l, sat_l}), 64'h0);
        step();
        run_vec(vecs[3], "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
